switch_arbiter: RTL and testbench

Round-robin arbiter that shares the switch's output ports between NUM_PORTS input requesters. Each requester presents one packet (source, target, data) with a valid/ready handshake. Per cycle, the arbiter grants at most one requester to each output port and forwards the packet to that output with the same IDLE/SEND cadence the output ports use. It sits between the ingress requesters and the per-port output stage of the switch.

---
 rtl/switch_arbiter_if.sv | 29 ++
 rtl/switch_arbiter.sv | 135 +++++++++++++
 tb/tb_switch_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_arbiter_if.sv
`default_nettype none
// ============================================================================
// switch_arbiter_if : requester/output bundle shared by the switch arbiter.
// Rev 1.0
// ============================================================================
interface switch_arbiter_if #(
  parameter int NUM_PORTS = 4
) ();
  logic [NUM_PORTS-1:0]   req_valid;
  logic [4*NUM_PORTS-1:0] req_source;
  logic [4*NUM_PORTS-1:0] req_target;
  logic [8*NUM_PORTS-1:0] req_data;
  logic [NUM_PORTS-1:0]   req_ready;
  logic [NUM_PORTS-1:0]   out_valid;
  logic [4*NUM_PORTS-1:0] out_source;
  logic [4*NUM_PORTS-1:0] out_target;
  logic [8*NUM_PORTS-1:0] out_data;

  modport master (
    output req_valid, req_source, req_target, req_data,
    input  req_ready, out_valid, out_source, out_target, out_data
  );

  modport slave (
    input  req_valid, req_source, req_target, req_data,
    output req_ready, out_valid, out_source, out_target, out_data
  );
endinterface
`default_nettype wire

// File: rtl/switch_arbiter.sv
`default_nettype none
// ============================================================================
// switch_arbiter : per-output round-robin arbiter, IDLE/SEND cadence per port.
// Optional saturating drop counter when SWITCH_ARB_DROP_CNT_EN is defined.
// Rev 1.0
// ============================================================================
module switch_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  switch_arbiter_if.slave bus
`ifdef SWITCH_ARB_DROP_CNT_EN
  ,
  output logic [7:0]      drop_count
`endif
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e                          state_q [NUM_PORTS];
  state_e                          state_d [NUM_PORTS];
  logic [NUM_PORTS-1:0][PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [4*NUM_PORTS-1:0]          src_q, src_d;
  logic [4*NUM_PORTS-1:0]          tgt_q, tgt_d;
  logic [8*NUM_PORTS-1:0]          data_q, data_d;
  logic [NUM_PORTS-1:0]            grant_ready;
  logic [NUM_PORTS-1:0]            bad_tgt;
  logic                            found;
  int                              win;
  int                              idx;

  always_comb begin
    bad_tgt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bad_tgt[i] = bus.req_valid[i] &&
                   ({1'b0, bus.req_target[4*i +: 4]} >= 5'(NUM_PORTS));
    end
  end

  // Per-output scan starting at rr_ptr; only an IDLE output may grant.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    src_d       = src_q;
    tgt_d       = tgt_q;
    data_d      = data_q;
    grant_ready = '0;
    found       = 1'b0;
    win         = 0;
    idx         = 0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (state_q[j] == ST_SEND) begin
        state_d[j] = ST_IDLE;
      end else begin
        found = 1'b0;
        win   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = (int'(rr_ptr_q[j]) + k) % NUM_PORTS;
          if (!found && bus.req_valid[idx] &&
              (bus.req_target[4*idx +: 4] == 4'(j))) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          state_d[j]          = ST_SEND;
          grant_ready[win]    = 1'b1;
          src_d[4*j +: 4]     = bus.req_source[4*win +: 4];
          tgt_d[4*j +: 4]     = bus.req_target[4*win +: 4];
          data_d[8*j +: 8]    = bus.req_data[8*win +: 8];
          rr_ptr_d[j]         = PTR_W'((win + 1) % NUM_PORTS);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        state_q[j] <= ST_IDLE;
      end
      rr_ptr_q <= '0;
      src_q    <= '0;
      tgt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      tgt_q    <= tgt_d;
      data_q   <= data_d;
    end
  end

  // Invalid-target packets are swallowed immediately; nothing accepts while in reset.
  assign bus.req_ready = rst_n ? (grant_ready | bad_tgt) : '0;

  always_comb begin
    bus.out_valid = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      bus.out_valid[j] = (state_q[j] == ST_SEND);
    end
  end

  assign bus.out_source = src_q;
  assign bus.out_target = tgt_q;
  assign bus.out_data   = data_q;

`ifdef SWITCH_ARB_DROP_CNT_EN
  logic [7:0] drop_count_q, drop_count_d;
  int         drop_sum;

  always_comb begin
    drop_sum = int'(drop_count_q) + $countones(bad_tgt);
    drop_count_d = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_arbiter.sv
`default_nettype none
// Bench for switch_arbiter: abstract grant model checked every cycle plus
// hand-computed literal expectations for each directed scenario.
module tb_switch_arbiter;
  localparam int NP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_arbiter_if #(.NUM_PORTS(NP)) bus ();

`ifdef SWITCH_ARB_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  switch_arbiter #(.NUM_PORTS(NP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SWITCH_ARB_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Model: each output remembers who it last served and whether it sent last cycle.
  logic       live = 1'b0;
  logic       m_valid [NP];
  int         m_last  [NP];
  logic [3:0] m_src   [NP];
  logic [3:0] m_tgt   [NP];
  logic [7:0] m_data  [NP];
  int         m_drop;
  logic       n_valid [NP];
  int         n_last  [NP];
  logic [3:0] n_src   [NP];
  logic [3:0] n_tgt   [NP];
  logic [7:0] n_data  [NP];
  int         n_drop;

  logic [NP-1:0]   e_ready, e_valid;
  logic [4*NP-1:0] e_src, e_tgt;
  logic [8*NP-1:0] e_data;

  always @(posedge clk) begin
    if (!rst_n) begin
      live = 1'b1;
      m_drop = 0;
      for (int j = 0; j < NP; j++) begin
        m_valid[j] = 1'b0;
        m_last[j]  = NP - 1;
        m_src[j]   = '0;
        m_tgt[j]   = '0;
        m_data[j]  = '0;
      end
    end else if (live) begin
      m_valid = n_valid;
      m_last  = n_last;
      m_src   = n_src;
      m_tgt   = n_tgt;
      m_data  = n_data;
      m_drop  = n_drop;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      e_ready = '0;
      n_drop  = m_drop;
      for (int j = 0; j < NP; j++) begin
        int best, bestd, d;
        n_valid[j] = 1'b0;
        n_last[j]  = m_last[j];
        n_src[j]   = m_src[j];
        n_tgt[j]   = m_tgt[j];
        n_data[j]  = m_data[j];
        best  = -1;
        bestd = NP;
        if (!m_valid[j]) begin
          for (int i = 0; i < NP; i++) begin
            if (bus.req_valid[i] && int'(bus.req_target[4*i +: 4]) == j) begin
              d = (((i - m_last[j] - 1) % NP) + NP) % NP;
              if (d < bestd) begin
                bestd = d;
                best  = i;
              end
            end
          end
        end
        if (best >= 0) begin
          e_ready[best] = 1'b1;
          n_valid[j] = 1'b1;
          n_last[j]  = best;
          n_src[j]   = bus.req_source[4*best +: 4];
          n_tgt[j]   = bus.req_target[4*best +: 4];
          n_data[j]  = bus.req_data[8*best +: 8];
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (bus.req_valid[i] && int'(bus.req_target[4*i +: 4]) >= NP) begin
          e_ready[i] = 1'b1;
          n_drop = (n_drop < 255) ? n_drop + 1 : 255;
        end
      end
      if (!rst_n) e_ready = '0;
      for (int j = 0; j < NP; j++) begin
        e_valid[j]        = m_valid[j];
        e_src[4*j +: 4]   = m_src[j];
        e_tgt[4*j +: 4]   = m_tgt[j];
        e_data[8*j +: 8]  = m_data[j];
      end
      chk("model_req_ready",  64'(bus.req_ready),  64'(e_ready));
      chk("model_out_valid",  64'(bus.out_valid),  64'(e_valid));
      chk("model_out_source", 64'(bus.out_source), 64'(e_src));
      chk("model_out_target", 64'(bus.out_target), 64'(e_tgt));
      chk("model_out_data",   64'(bus.out_data),   64'(e_data));
`ifdef SWITCH_ARB_DROP_CNT_EN
      chk("model_drop_count", 64'(drop_count), 64'(m_drop));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] src,
                         input logic [3:0] tgt, input logic [7:0] d);
    bus.req_valid[i]        = v;
    bus.req_source[4*i +: 4] = src;
    bus.req_target[4*i +: 4] = tgt;
    bus.req_data[8*i +: 8]   = d;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_source = '0;
    bus.req_target = '0;
    bus.req_data   = '0;

    // Reset held with every requester contending for output 0
    for (int i = 0; i < NP; i++) set_req(i, 1'b1, 4'(i), 4'd0, 8'(8'h10 + i));
    repeat (3) begin
      step();
      @(negedge clk);
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_lanes", 64'({bus.out_source, bus.out_target, bus.out_data}), 64'h0);
    end

    // Round-robin on output 0: winners 0,1,2,3,0 every other cycle
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_grant0", 64'(bus.req_ready), 64'h1);
    for (int k = 1; k <= 9; k++) begin
      step();
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << ((k / 2) % 4)));
        chk("rr_gap_valid", 64'(bus.out_valid), 64'h0);
      end else begin
        chk("rr_wait_ready", 64'(bus.req_ready), 64'h0);
        chk("rr_out_valid", 64'(bus.out_valid), 64'h1);
        chk("rr_out_source", 64'(bus.out_source[3:0]), 64'(((k - 1) / 2) % 4));
      end
    end
    step();
    bus.req_valid = '0;
    step();

    // Single packet 2 -> output 1
    set_req(2, 1'b1, 4'd2, 4'd1, 8'hA5);
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'h4);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("single_out_valid", 64'(bus.out_valid), 64'h2);
    chk("single_source", 64'(bus.out_source[7:4]), 64'h2);
    chk("single_target", 64'(bus.out_target[7:4]), 64'h1);
    chk("single_data", 64'(bus.out_data[15:8]), 64'hA5);
    step();
    @(negedge clk);
    chk("single_once", 64'(bus.out_valid), 64'h0);

    // Parallel: 0 -> 3 and 1 -> 2 in the same cycle
    step();
    set_req(0, 1'b1, 4'd0, 4'd3, 8'h3C);
    set_req(1, 1'b1, 4'd1, 4'd2, 8'hC3);
    @(negedge clk);
    chk("par_ready", 64'(bus.req_ready), 64'h3);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("par_out_valid", 64'(bus.out_valid), 64'hC);
    chk("par_data3", 64'(bus.out_data[31:24]), 64'h3C);
    chk("par_data2", 64'(bus.out_data[23:16]), 64'hC3);

    // Invalid target, 300 back-to-back drops
    step();
    set_req(1, 1'b1, 4'd1, 4'd7, 8'hEE);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      chk("drop_ready", 64'(bus.req_ready), 64'h2);
      if (n > 0) chk("drop_no_out", 64'(bus.out_valid), 64'h0);
      step();
    end
    bus.req_valid = '0;
    @(negedge clk);
`ifdef SWITCH_ARB_DROP_CNT_EN
    chk("drop_saturate", 64'(drop_count), 64'd255);
`endif
    chk("drop_idle", 64'(bus.req_ready), 64'h0);

    // Reset mid-SEND: grant 2 -> output 2, reset sampled at end of that cycle
    step();
    set_req(2, 1'b1, 4'd2, 4'd2, 8'h33);
    @(negedge clk);
    chk("midrst_grant", 64'(bus.req_ready), 64'h4);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req_valid = '0;
    set_req(1, 1'b1, 4'd1, 4'd2, 8'h11);
    set_req(3, 1'b1, 4'd3, 4'd2, 8'h77);
    @(negedge clk);
    chk("midrst_lost", 64'(bus.out_valid), 64'h0);
    chk("midrst_ptr_reset", 64'(bus.req_ready), 64'h2);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h4);
    chk("midrst_out_source", 64'(bus.out_source[11:8]), 64'h1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
